// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM state encoding and the alignment check for the data RAM port.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   // Only the low two address bits matter; size 11 is never legal.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return (size == 2'b11) || (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_extend.sv
// load_extend: zero/sign-extends right-justified byte or halfword load data; words pass through.
module load_extend
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] raw_i,
   output logic [31:0] ext_o
);

   assign ext_o = (size_i == SZ_BYTE) ? {{24{signed_i & raw_i[7]}}, raw_i[7:0]} :
                  (size_i == SZ_HALF) ? {{16{signed_i & raw_i[15]}}, raw_i[15:0]} :
                                        raw_i;

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage initiator for the byte-addressed big-endian data RAM,
// one request at a time with valid/ready on both sides and misalignment rejection.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_enable,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_size,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic              busy
);

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              signed_q;
   logic              mem_enable_q, mem_rw_q, resp_err_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [1:0]        mem_size_q;
   logic [31:0]       mem_din_q, resp_rdata_q, ext;

   load_extend u_ext (
      .size_i  (mem_size_q),
      .signed_i(signed_q),
      .raw_i   (mem_dout),
      .ext_o   (ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         signed_q     <= 1'b0;
         mem_enable_q <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_size_q   <= '0;
         mem_din_q    <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               resp_rdata_q <= '0;
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  resp_err_q <= 1'b1;
                  state_q    <= RESP;
               end else begin
                  mem_enable_q <= 1'b1;
                  mem_rw_q     <= req_write;
                  mem_addr_q   <= req_addr;
                  mem_size_q   <= req_size;
                  mem_din_q    <= req_wdata;
                  signed_q     <= req_signed;
                  cnt_q        <= 4'(WAIT_CYCLES - 1);
                  resp_err_q   <= 1'b0;
                  state_q      <= ACCESS;
               end
            end
            ACCESS: if (cnt_q == 4'd0) begin
               // RAM read is combinational, so dout is valid on the last enabled cycle
               resp_rdata_q <= mem_rw_q ? 32'd0 : ext;
               mem_enable_q <= 1'b0;
               mem_rw_q     <= 1'b0;
               state_q      <= RESP;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
            RESP: if (resp_ready) begin
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_enable = mem_enable_q;
   assign mem_rw     = mem_rw_q;
   assign mem_addr   = mem_addr_q;
   assign mem_size   = mem_size_q;
   assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed checks of two controllers (1 and 3 wait cycles) against byte RAM models.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [7:0]  req_addr = 8'h00;
   logic [31:0] req_wdata = 32'h0;
   logic        valid1 = 1'b0, valid3 = 1'b0;

   logic        ready1, rv1, err1, en1, rw1, busy1;
   logic        ready3, rv3, err3, en3, rw3, busy3;
   logic [31:0] rdata1, din1, dout1, rdata3, din3, dout3;
   logic [7:0]  addr1, addr3;
   logic [1:0]  size1, size3;

   logic [7:0]  ram1 [256];
   logic [7:0]  ram3 [256];

   int vec = 0, errs = 0;
   int en_cnt1 = 0, en_cnt3 = 0, rv_cnt3 = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.WAIT_CYCLES(1), .ADDR_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rdata1), .resp_err(err1),
      .mem_enable(en1), .mem_rw(rw1), .mem_addr(addr1), .mem_size(size1), .mem_din(din1),
      .mem_dout(dout1), .busy(busy1));

   dmem_access_ctrl #(.WAIT_CYCLES(3), .ADDR_W(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv3), .resp_ready(resp_ready), .resp_rdata(rdata3), .resp_err(err3),
      .mem_enable(en3), .mem_rw(rw3), .mem_addr(addr3), .mem_size(size3), .mem_din(din3),
      .mem_dout(dout3), .busy(busy3));

   // Big-endian, right-justified combinational read
   function automatic logic [31:0] rd_be(input logic [1:0] sz, input logic [7:0] b0, b1, b2, b3);
      return (sz == 2'b00) ? {24'h0, b0} : (sz == 2'b01) ? {16'h0, b0, b1} : {b0, b1, b2, b3};
   endfunction

   assign dout1 = rd_be(size1, ram1[addr1], ram1[addr1 + 8'd1], ram1[addr1 + 8'd2], ram1[addr1 + 8'd3]);
   assign dout3 = rd_be(size3, ram3[addr3], ram3[addr3 + 8'd1], ram3[addr3 + 8'd2], ram3[addr3 + 8'd3]);

   always @(posedge clk) if (en1 && rw1) begin
      if (size1 == 2'b00) ram1[addr1] <= din1[7:0];
      else if (size1 == 2'b01) begin ram1[addr1] <= din1[15:8]; ram1[addr1 + 8'd1] <= din1[7:0]; end
      else begin
         ram1[addr1] <= din1[31:24]; ram1[addr1 + 8'd1] <= din1[23:16];
         ram1[addr1 + 8'd2] <= din1[15:8]; ram1[addr1 + 8'd3] <= din1[7:0];
      end
   end

   always @(negedge clk) begin
      en_cnt1 += int'(en1);
      en_cnt3 += int'(en3);
      rv_cnt3 += int'(rv3);
   end

   // Issue one request to the chosen DUT and complete its response handshake immediately.
   task automatic do_req(input bit sel3, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      if (sel3) valid3 = 1'b1; else valid1 = 1'b1;
      @(posedge clk); #1;
      valid1 = 1'b0; valid3 = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); lat++;
         if (sel3 ? rv3 : rv1) break;
      end
      rd = sel3 ? rdata3 : rdata1;
      er = sel3 ? err3 : err1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      vec++; if (ready1 !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", ready1); end
      vec++; if ({en1, rw1, rv1, err1, busy1} !== 5'b0) begin errs++; $display("FAIL reset_ctrl got %b exp 00000", {en1, rw1, rv1, err1, busy1}); end
      vec++; if ({rdata1, din1, addr1, size1} !== 74'h0) begin errs++; $display("FAIL reset_data got %h exp 0", {rdata1, din1, addr1, size1}); end
      vec++; if ({ready3, en3, busy3, rv3} !== 4'b1000) begin errs++; $display("FAIL reset_dut3 got %b exp 1000", {ready3, en3, busy3, rv3}); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vec++; if (ready1 !== 1'b1 || busy1 !== 1'b0) begin errs++; $display("FAIL post_reset got ready=%b busy=%b exp 1/0", ready1, busy1); end
   endtask

   task automatic test_loads();
      logic [31:0] rd; logic er; int lat;
      logic [31:0] exp_d [5] = '{32'h8001FF7E, 32'hFFFFFF80, 32'h00000080, 32'hFFFFFF7E, 32'h00008001};
      logic [1:0]  szs   [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
      logic        sgs   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0]  ads   [5] = '{8'h10, 8'h10, 8'h10, 8'h12, 8'h10};
      for (int k = 0; k < 5; k++) begin
         do_req(1'b0, 1'b0, szs[k], sgs[k], ads[k], 32'h0, rd, er, lat);
         vec++; if (rd !== exp_d[k]) begin errs++; $display("FAIL load%0d_data got %h exp %h", k, rd, exp_d[k]); end
         vec++; if (er !== 1'b0) begin errs++; $display("FAIL load%0d_err got %b exp 0", k, er); end
         vec++; if (lat !== 2) begin errs++; $display("FAIL load%0d_latency got %0d exp 2", k, lat); end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 8'hFC, 32'hDEADBEEF, rd, er, lat);
      vec++; if (rd !== 32'h0 || er !== 1'b0) begin errs++; $display("FAIL stw_resp got %h/%b exp 0/0", rd, er); end
      do_req(1'b0, 1'b0, 2'b10, 1'b0, 8'hFC, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL ldw_fc got %h exp deadbeef", rd); end
      do_req(1'b0, 1'b1, 2'b00, 1'b0, 8'h20, 32'h123456AB, rd, er, lat);
      vec++; if (ram1[8'h21] !== 8'h00 || ram1[8'h20] !== 8'hAB) begin errs++; $display("FAIL stb_ram got %h%h exp ab00", ram1[8'h20], ram1[8'h21]); end
      do_req(1'b0, 1'b0, 2'b00, 1'b0, 8'h20, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'h000000AB) begin errs++; $display("FAIL ldb_20 got %h exp 000000ab", rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic er; int lat, base;
      logic [1:0] szs [3] = '{2'b10, 2'b01, 2'b11};
      logic [7:0] ads [3] = '{8'h02, 8'h05, 8'h00};
      base = en_cnt1;
      for (int k = 0; k < 3; k++) begin
         do_req(1'b0, 1'b0, szs[k], 1'b0, ads[k], 32'h0, rd, er, lat);
         vec++; if (er !== 1'b1 || rd !== 32'h0) begin errs++; $display("FAIL mis%0d_resp got %b/%h exp 1/0", k, er, rd); end
         vec++; if (lat !== 1) begin errs++; $display("FAIL mis%0d_latency got %0d exp 1", k, lat); end
      end
      vec++; if (en_cnt1 - base !== 0) begin errs++; $display("FAIL mis_enable got %0d cycles exp 0", en_cnt1 - base); end
   endtask

   task automatic test_backpressure();
      int base, lat;
      base = en_cnt3;
      @(negedge clk);
      req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'h10; valid3 = 1'b1;
      @(posedge clk); #1;
      req_size = 2'b00; req_addr = 8'h13;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); lat++;
         if (rv3) break;
      end
      vec++; if (lat !== 4) begin errs++; $display("FAIL bp_latency got %0d exp 4", lat); end
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (rv3 !== 1'b1 || rdata3 !== 32'h8001FF7E || ready3 !== 1'b0) begin
            errs++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b exp 1/8001ff7e/0", i, rv3, rdata3, ready3);
         end
         @(negedge clk);
      end
      vec++; if (en_cnt3 - base !== 3) begin errs++; $display("FAIL bp_enable got %0d cycles exp 3", en_cnt3 - base); end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      vec++; if (ready3 !== 1'b1 || rv3 !== 1'b0 || en3 !== 1'b0) begin errs++; $display("FAIL bp_after_hs got rdy=%b v=%b en=%b exp 1/0/0", ready3, rv3, en3); end
      @(posedge clk); #1;
      valid3 = 1'b0;
      @(negedge clk);
      vec++; if (en3 !== 1'b1 || addr3 !== 8'h13 || ready3 !== 1'b0) begin errs++; $display("FAIL bp_second_accept got en=%b a=%h rdy=%b exp 1/13/0", en3, addr3, ready3); end
      for (int i = 0; i < 20 && !rv3; i++) @(negedge clk);
      vec++; if (rv3 !== 1'b1 || rdata3 !== 32'h0000007E) begin errs++; $display("FAIL bp_second_data got v=%b d=%h exp 1/0000007e", rv3, rdata3); end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int base;
      @(negedge clk);
      req_write = 1'b0; req_size = 2'b10; req_addr = 8'h10; valid3 = 1'b1;
      @(posedge clk); #1;
      valid3 = 1'b0;
      base = rv_cnt3;
      @(negedge clk);
      vec++; if (en3 !== 1'b1 || busy3 !== 1'b1) begin errs++; $display("FAIL mid_pre got en=%b busy=%b exp 1/1", en3, busy3); end
      #2 rst_n = 1'b0;
      #1;
      vec++; if (en3 !== 1'b0 || busy3 !== 1'b0 || ready3 !== 1'b1) begin errs++; $display("FAIL mid_async got en=%b busy=%b rdy=%b exp 0/0/1", en3, busy3, ready3); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      vec++; if (rv_cnt3 - base !== 0 || busy3 !== 1'b0) begin errs++; $display("FAIL mid_no_resp got %0d resp cycles busy=%b exp 0/0", rv_cnt3 - base, busy3); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin ram1[i] = 8'h00; ram3[i] = 8'h00; end
      {ram1[8'h10], ram1[8'h11], ram1[8'h12], ram1[8'h13]} = 32'h8001FF7E;
      {ram3[8'h10], ram3[8'h11], ram3[8'h12], ram3[8'h13]} = 32'h8001FF7E;
      test_reset();
      test_loads();
      test_store_load();
      test_misaligned();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator side of the 256x8 byte-addressed, big-endian data RAM port; sits in the MEM stage between the pipeline's load/store unit and the RAM.
- Accepts one load/store request at a time over a valid/ready handshake and rejects misaligned accesses.
- Drives RAM Enable/ReadWrite/Address/Size/DataIn for a programmable number of cycles.
- Captures DataOut, zero- or sign-extends load data, and returns a response over a valid/ready handshake.

Parameters:
- WAIT_CYCLES, 1, cycles mem_enable is held per access (1..15).
- ADDR_W, 8, RAM address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  0: load, 1: store
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  load sign-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request
- mem_enable  out  1  to RAM Enable
- mem_rw  out  1  to RAM ReadWrite (0 read, 1 write)
- mem_addr  out  ADDR_W  to RAM Address
- mem_size  out  2  to RAM Size
- mem_din  out  32  to RAM DataIn
- mem_dout  in  32  from RAM DataOut (combinational read)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous and active-low.
  - Asserting rst_n low forces state IDLE, the wait counter to 0, and all mem_* outputs, resp_valid, resp_err, resp_rdata and busy to 0. req_ready is 1.
  - Reset mid-access drops mem_enable immediately. A partially performed store is not retried.
- Registered outputs: all mem_* outputs are registered.
- States:
  - IDLE: req_ready=1.
    - On req_valid&req_ready with an aligned, legal request: latch the request, drive mem_* with mem_enable=1, load counter=WAIT_CYCLES-1, go to ACCESS.
    - On an illegal request: go to RESP with resp_err=1 and resp_rdata=0. mem_enable is never asserted.
  - ACCESS: req_ready=0, mem_enable=1, mem_* held stable.
    - Counter decrements each cycle.
    - At the edge where the counter is 0: loads capture mem_dout into the extender, mem_enable and mem_rw go to 0, and state goes to RESP.
  - RESP: resp_valid=1; outputs held stable until resp_ready=1, then state goes to IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency: request accepted at edge T → mem_enable high for cycles T+1..T+WAIT_CYCLES → resp_valid from T+WAIT_CYCLES+1. Error responses have resp_valid from T+1.
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0; size 11 is always an error.
  - Aligned accesses never wrap past 8'hFF. Word at 8'hFC and halfword at 8'hFE are legal.
- Load extension (mem_dout is right-justified big-endian):
  - Byte: bits[7:0], extended from bit 7 when req_signed=1, otherwise zero-extended.
  - Halfword: bits[15:0], extended from bit 15 the same way.
  - Word: passed through; req_signed is ignored.
- Store: mem_din = req_wdata unmodified (the RAM uses the low bytes); mem_rw=1. The write is level-sensitive and repeating it over multiple enable cycles is idempotent. resp_rdata=0.
- Simultaneous events: req_valid during ACCESS/RESP is ignored (req_ready=0); the requester must hold it. resp_ready while not in RESP has no effect.

Decomposition:
- Package dmem_pkg:
  - Constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding IDLE/ACCESS/RESP.
  - Function is_misaligned(size, addr).
- One natural sub-module: load_extend (combinational; size, signed, raw 32 → extended 32). Instantiated once, also reusable by the writeback path.

Test Plan:
- RAM at 0x10..0x13 = 8'h80,8'h01,8'hFF,8'h7E, WAIT_CYCLES=1:
  - LDW 0x10 → resp_rdata=32'h8001FF7E, err=0, resp_valid exactly 2 cycles after acceptance.
  - LDB signed 0x10 → 32'hFFFFFF80; LDB unsigned 0x10 → 32'h00000080.
  - LDH signed 0x12 → 32'hFFFFFF7E; LDH unsigned 0x10 → 32'h00008001.
- Store then load: STW 0xFC data 32'hDEADBEEF, then LDW 0xFC → 32'hDEADBEEF. STB 0x20 data 32'h123456AB, then LDB unsigned 0x20 → 32'h000000AB.
- Misaligned: LDW 0x02, LDH 0x05, size 11 → resp_err=1, rdata=0, mem_enable never high (monitor), resp_valid 1 cycle after acceptance.
- Backpressure with WAIT_CYCLES=3: hold resp_ready=0 for 4 cycles → resp_valid and resp_rdata stable, req_ready=0, mem_enable high for exactly 3 cycles. Next request accepted only after the handshake.
- Reset mid-access: rst_n low during ACCESS → mem_enable=0 and busy=0 in the same cycle without a clock edge, req_ready=1, no resp_valid ever issued for that request.
